// File: rtl/clint_bus_arbiter.sv
// -----------------------------------------------------------------------------
// clint_bus_arbiter
//
// Shares the single register port of the CLINT timer block between
// NR_MASTERS requesters. A round-robin arbiter picks one requester at a time.
// Its command is carried to the CLINT port as the single outstanding
// transaction. The response is returned to the winning requester. A stalled
// transaction is aborted with an error after TIMEOUT cycles (0 disables this).
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_i, we_i         per-master request (level) and write enable
//   addr_i, wdata_i,    per-master command fields, packed with master 0 in
//   be_i                the LSBs
//   gnt_o               one-hot grant pulse (combinational, IDLE only)
//   rvalid_o            one-hot response-valid pulse
//   rdata_o, err_o      response data / error, held until the next response
//   slv_req_o, slv_we_o,
//   slv_addr_o,
//   slv_wdata_o,
//   slv_be_o            command to the CLINT register port
//   slv_gnt_i           CLINT accepts the command
//   slv_rvalid_i,
//   slv_rdata_i,
//   slv_err_i           CLINT response
// -----------------------------------------------------------------------------
module clint_bus_arbiter #(
    parameter int NR_MASTERS = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_MASTERS-1:0]            req_i,
    input  logic [NR_MASTERS-1:0]            we_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_MASTERS*DATA_WIDTH/8-1:0] be_i,
    output logic [NR_MASTERS-1:0]            gnt_o,
    output logic [NR_MASTERS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o,
    output logic                             slv_req_o,
    output logic                             slv_we_o,
    output logic [ADDR_WIDTH-1:0]            slv_addr_o,
    output logic [DATA_WIDTH-1:0]            slv_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          slv_be_o,
    input  logic                             slv_gnt_i,
    input  logic                             slv_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            slv_rdata_i,
    input  logic                             slv_err_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NR_MASTERS);
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    // Latched command of the transaction in flight.
    logic [IDX_W-1:0]      cmd_idx_q;
    logic                  cmd_we_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [BE_WIDTH-1:0]   cmd_be_q;

    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic                  complete;
    logic                  expire;

    // ------------------------------------------------------------------
    // Round-robin arbitration: first requester at or above ptr, wrapping.
    // ------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default
    // at the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NR_MASTERS) begin
                cand = cand - NR_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (!win_valid && req_i[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (state_q == S_IDLE && win_valid) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // A response in REQ only counts when the command is accepted alongside.
    assign complete = ((state_q == S_REQ) && slv_gnt_i && slv_rvalid_i) ||
                      ((state_q == S_RSP) && slv_rvalid_i);

    // Completion in the expiry cycle takes precedence over the abort.
    assign expire   = (TIMEOUT > 0) && (state_q != S_IDLE) &&
                      (cnt_q == CNT_LAST) && !complete;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) state_d = S_REQ;
            end
            S_REQ: begin
                if (complete || expire) state_d = S_IDLE;
                else if (slv_gnt_i)     state_d = S_RSP;
            end
            S_RSP: begin
                if (complete || expire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointer, command and response registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples the pre-edge values of the others.
    // NOTE: the command registers are reset too: they drive the slv_*
    // outputs directly and those must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            cmd_idx_q   <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_be_q    <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_o <= '0;
            if (state_q == S_IDLE) begin
                if (win_valid) begin
                    cmd_idx_q   <= win_idx;
                    cmd_we_q    <= we_i[win_idx];
                    cmd_addr_q  <= addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_wdata_q <= wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    cmd_be_q    <= be_i[int'(win_idx)*BE_WIDTH +: BE_WIDTH];
                    ptr_q       <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
                    cnt_q       <= '0;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (complete) begin
                    rvalid_o[cmd_idx_q] <= 1'b1;
                    rdata_o             <= slv_rdata_i;
                    err_o               <= slv_err_i;
                end else if (expire) begin
                    rvalid_o[cmd_idx_q] <= 1'b1;
                    rdata_o             <= '0;
                    err_o               <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // CLINT port
    // ------------------------------------------------------------------
    assign slv_req_o   = (state_q == S_REQ);
    assign slv_we_o    = cmd_we_q;
    assign slv_addr_o  = cmd_addr_q;
    assign slv_wdata_o = cmd_wdata_q;
    assign slv_be_o    = cmd_be_q;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clint_bus_arbiter
//
// Directed testbench for clint_bus_arbiter with two masters and TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 unit
// later, well away from the next edge. "Cycle n" of a scenario is the clock
// period in which the grant of that scenario is expected (n = 0).
// -----------------------------------------------------------------------------
module tb_clint_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int T  = 8;

    logic              clk;
    logic              rst_ni;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*BW-1:0]   be;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              slv_req_o;
    logic              slv_we_o;
    logic [AW-1:0]     slv_addr_o;
    logic [DW-1:0]     slv_wdata_o;
    logic [BW-1:0]     slv_be_o;
    logic              slv_gnt_i;
    logic              slv_rvalid_i;
    logic [DW-1:0]     slv_rdata_i;
    logic              slv_err_i;

    int checks = 0;
    int errors = 0;

    clint_bus_arbiter #(
        .NR_MASTERS (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (T)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .slv_req_o    (slv_req_o),
        .slv_we_o     (slv_we_o),
        .slv_addr_o   (slv_addr_o),
        .slv_wdata_o  (slv_wdata_o),
        .slv_be_o     (slv_be_o),
        .slv_gnt_i    (slv_gnt_i),
        .slv_rvalid_i (slv_rvalid_i),
        .slv_rdata_i  (slv_rdata_i),
        .slv_err_i    (slv_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic slave_idle();
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b0;
        slv_rdata_i  = '0;
        slv_err_i    = 1'b0;
    endtask

    initial begin
        logic       prev_gnt;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;

        rst_ni = 1'b0;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        be     = '0;
        slave_idle();
        #2;

        // ---------------- Reset state ----------------
        check("rst_gnt",    64'(gnt_o),       64'h0);
        check("rst_rvalid", 64'(rvalid_o),    64'h0);
        check("rst_rdata",  rdata_o,          64'h0);
        check("rst_err",    64'(err_o),       64'h0);
        check("rst_sreq",   64'(slv_req_o),   64'h0);
        check("rst_swe",    64'(slv_we_o),    64'h0);
        check("rst_saddr",  64'(slv_addr_o),  64'h0);
        check("rst_swdata", slv_wdata_o,      64'h0);
        check("rst_sbe",    64'(slv_be_o),    64'h0);
        tick();
        tick();
        rst_ni = 1'b1;

        // ---------------- Single read by master 1 ----------------
        tick();                                   // cycle 0
        req            = 2'b10;
        we             = 2'b00;
        addr[31:16]    = 16'hBFF8;
        settle();
        check("rd_gnt_c0",  64'(gnt_o),     64'h2);
        check("rd_sreq_c0", 64'(slv_req_o), 64'h0);
        tick();                                   // cycle 1
        req       = 2'b00;
        slv_gnt_i = 1'b1;
        settle();
        check("rd_sreq_c1",  64'(slv_req_o),  64'h1);
        check("rd_saddr_c1", 64'(slv_addr_o), 64'hBFF8);
        check("rd_swe_c1",   64'(slv_we_o),   64'h0);
        check("rd_gnt_c1",   64'(gnt_o),      64'h0);
        tick();                                   // cycle 2
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 64'h0000_0000_0001_2345;
        settle();
        check("rd_sreq_c2",   64'(slv_req_o), 64'h0);
        check("rd_rvalid_c2", 64'(rvalid_o),  64'h0);
        tick();                                   // cycle 3
        slave_idle();
        settle();
        check("rd_rvalid_c3", 64'(rvalid_o), 64'h2);
        check("rd_rdata_c3",  rdata_o,       64'h12345);
        check("rd_err_c3",    64'(err_o),    64'h0);
        tick();                                   // cycle 4
        settle();
        check("rd_rvalid_c4", 64'(rvalid_o), 64'h0);

        // ---------------- Round robin, immediate-response slave ----------------
        prev_gnt = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            req          = 2'b11;
            we           = 2'b00;
            slv_gnt_i    = slv_req_o;
            slv_rvalid_i = prev_gnt;
            slv_rdata_i  = 64'(c);
            settle();
            exp_gnt = (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rv  = (c % 3 == 0 && c > 0) ? (((c / 3) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("rr_gnt_c%0d", c),    64'(gnt_o),    64'(exp_gnt));
            check($sformatf("rr_rvalid_c%0d", c), 64'(rvalid_o), 64'(exp_rv));
            if (exp_rv != 2'b00) begin
                check($sformatf("rr_rdata_c%0d", c), rdata_o, 64'(c - 1));
            end
            prev_gnt = slv_gnt_i;
        end
        tick();                                   // drain the last response
        req = 2'b00;
        slave_idle();
        settle();
        check("rr_rvalid_last", 64'(rvalid_o), 64'h2);
        check("rr_gnt_last",    64'(gnt_o),    64'h0);

        // ---------------- Write passthrough, slave stalls 4 cycles ----------------
        tick();                                   // cycle 0
        req          = 2'b01;
        we           = 2'b01;
        addr[15:0]   = 16'h4000;
        wdata[63:0]  = 64'h0000_0000_DEAD_BEEF;
        be[7:0]      = 8'h0F;
        settle();
        check("wr_gnt_c0", 64'(gnt_o), 64'h1);
        for (int i = 0; i < 5; i++) begin         // cycles 1..5
            tick();
            req         = 2'b00;
            we          = 2'b00;
            addr[15:0]  = 16'h1111;               // master inputs change, command must not
            wdata[63:0] = 64'h5555_5555_5555_5555;
            be[7:0]     = 8'hF0;
            slv_gnt_i   = (i == 4);
            settle();
            check($sformatf("wr_sreq_c%0d", i + 1),   64'(slv_req_o),  64'h1);
            check($sformatf("wr_saddr_c%0d", i + 1),  64'(slv_addr_o), 64'h4000);
            check($sformatf("wr_swdata_c%0d", i + 1), slv_wdata_o,     64'hDEAD_BEEF);
            check($sformatf("wr_sbe_c%0d", i + 1),    64'(slv_be_o),   64'h0F);
            check($sformatf("wr_swe_c%0d", i + 1),    64'(slv_we_o),   64'h1);
        end
        tick();                                   // cycle 6: RSP
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 64'hA5A5;
        settle();
        check("wr_sreq_c6",   64'(slv_req_o), 64'h0);
        check("wr_rvalid_c6", 64'(rvalid_o),  64'h0);
        tick();                                   // cycle 7
        slave_idle();
        settle();
        check("wr_rvalid_c7", 64'(rvalid_o), 64'h1);
        check("wr_rdata_c7",  rdata_o,       64'hA5A5);
        check("wr_err_c7",    64'(err_o),    64'h0);
        tick();                                   // cycle 8
        settle();
        check("wr_rvalid_c8", 64'(rvalid_o), 64'h0);

        // ---------------- Timeout, slave never grants (master 1) ----------------
        tick();                                   // cycle 0
        req         = 2'b10;
        we          = 2'b00;
        addr[31:16] = 16'h4008;
        settle();
        check("to_gnt_c0", 64'(gnt_o), 64'h2);
        for (int c = 1; c <= T; c++) begin        // cycles 1..8
            tick();
            req = 2'b00;
            settle();
            check($sformatf("to_sreq_c%0d", c),   64'(slv_req_o), 64'h1);
            check($sformatf("to_rvalid_c%0d", c), 64'(rvalid_o),  64'h0);
        end
        tick();                                   // cycle 9
        slv_gnt_i    = 1'b1;                      // stray handshake while IDLE
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 64'hFFFF;
        settle();
        check("to_rvalid_c9", 64'(rvalid_o),  64'h2);
        check("to_err_c9",    64'(err_o),     64'h1);
        check("to_rdata_c9",  rdata_o,        64'h0);
        check("to_sreq_c9",   64'(slv_req_o), 64'h0);
        tick();                                   // cycle 10
        slave_idle();
        settle();
        check("to_stray_rvalid", 64'(rvalid_o),  64'h0);
        check("to_stray_sreq",   64'(slv_req_o), 64'h0);

        // ---------------- Slave error coinciding with expiry (master 0) ----------------
        tick();                                   // cycle 0
        req        = 2'b01;
        addr[15:0] = 16'h0000;
        settle();
        check("se_gnt_c0", 64'(gnt_o), 64'h1);
        for (int c = 1; c <= T; c++) begin        // cycles 1..8
            tick();
            req          = 2'b00;
            slv_gnt_i    = (c == 1);
            slv_rvalid_i = (c == T);
            slv_err_i    = (c == T);
            slv_rdata_i  = (c == T) ? 64'hCAFE_0000_1234_5678 : 64'h0;
            settle();
            check($sformatf("se_rvalid_c%0d", c), 64'(rvalid_o), 64'h0);
        end
        tick();                                   // cycle 9
        slave_idle();
        settle();
        check("se_rvalid_c9", 64'(rvalid_o), 64'h1);
        check("se_err_c9",    64'(err_o),    64'h1);
        check("se_rdata_c9",  rdata_o,       64'hCAFE_0000_1234_5678);
        tick();                                   // cycle 10
        settle();
        check("se_rvalid_c10", 64'(rvalid_o), 64'h0);

        // ---------------- Reset mid-transaction ----------------
        tick();                                   // cycle 0: ptr=1, master 1 wins
        req           = 2'b11;
        we            = 2'b10;
        addr[31:16]   = 16'h0008;
        wdata[127:64] = 64'h55;
        be[15:8]      = 8'hFF;
        settle();
        check("mr_gnt_c0", 64'(gnt_o), 64'h2);
        tick();                                   // cycle 1
        req       = 2'b01;
        slv_gnt_i = 1'b1;
        settle();
        check("mr_saddr_c1", 64'(slv_addr_o), 64'h0008);
        check("mr_swe_c1",   64'(slv_we_o),   64'h1);
        tick();                                   // cycle 2: RSP
        slv_gnt_i = 1'b0;
        req       = 2'b00;
        rst_ni    = 1'b0;
        settle();
        check("mr_gnt",    64'(gnt_o),       64'h0);
        check("mr_rvalid", 64'(rvalid_o),    64'h0);
        check("mr_rdata",  rdata_o,          64'h0);
        check("mr_err",    64'(err_o),       64'h0);
        check("mr_sreq",   64'(slv_req_o),   64'h0);
        check("mr_swe",    64'(slv_we_o),    64'h0);
        check("mr_saddr",  64'(slv_addr_o),  64'h0);
        check("mr_swdata", slv_wdata_o,      64'h0);
        check("mr_sbe",    64'(slv_be_o),    64'h0);
        tick();
        slv_rvalid_i = 1'b1;                      // response of the aborted transaction
        slv_rdata_i  = 64'h77;
        settle();
        tick();
        rst_ni = 1'b1;
        slave_idle();
        settle();
        check("mr_rvalid_rel", 64'(rvalid_o), 64'h0);
        tick();
        req = 2'b11;
        settle();
        check("mr_gnt_after", 64'(gnt_o),    64'h1);
        check("mr_rvalid_after", 64'(rvalid_o), 64'h0);
        tick();
        req = 2'b00;
        settle();
        check("mr_sreq_after", 64'(slv_req_o), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
